// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_if
//  Description : Issue / writeback / status bundle for hazard_scoreboard.
//                master : decode/issue side (drives issue_* and wb_*,
//                         observes stall and scoreboard status)
//                slave  : the scoreboard itself
//  Signals     : issue_valid, issue_regWrite, issue_long, issue_dest,
//                issue_src1, issue_src2, issue_use1, issue_use2,
//                wb_valid, wb_dest                     (master -> slave)
//                stall, busy, outstanding, err_spurious (slave -> master)
//                stall_cycles (slave -> master, only with
//                HAZARD_SCOREBOARD_STATS_EN defined)
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int REG_AW          = 3,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int NREGS = 2 ** REG_AW;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic              issue_valid;
    logic              issue_regWrite;
    logic              issue_long;
    logic [REG_AW-1:0] issue_dest;
    logic [REG_AW-1:0] issue_src1;
    logic [REG_AW-1:0] issue_src2;
    logic              issue_use1;
    logic              issue_use2;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dest;

    logic              stall;
    logic [NREGS-1:0]  busy;
    logic [CNT_W-1:0]  outstanding;
    logic              err_spurious;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0]       stall_cycles;

    modport master (
        output issue_valid, issue_regWrite, issue_long, issue_dest,
               issue_src1, issue_src2, issue_use1, issue_use2,
               wb_valid, wb_dest,
        input  stall, busy, outstanding, err_spurious, stall_cycles
    );
    modport slave (
        input  issue_valid, issue_regWrite, issue_long, issue_dest,
               issue_src1, issue_src2, issue_use1, issue_use2,
               wb_valid, wb_dest,
        output stall, busy, outstanding, err_spurious, stall_cycles
    );
`else
    modport master (
        output issue_valid, issue_regWrite, issue_long, issue_dest,
               issue_src1, issue_src2, issue_use1, issue_use2,
               wb_valid, wb_dest,
        input  stall, busy, outstanding, err_spurious
    );
    modport slave (
        input  issue_valid, issue_regWrite, issue_long, issue_dest,
               issue_src1, issue_src2, issue_use1, issue_use2,
               wb_valid, wb_dest,
        output stall, busy, outstanding, err_spurious
    );
`endif
endinterface : hazard_scoreboard_if
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Producer-side hazard tracker at decode/issue. Records
//                in-flight long-latency writers (load/mul) per architectural
//                register and stalls issue of RAW- or WAW-dependent
//                instructions until the writer's writeback. Short writers
//                are left to the forwarding network and are not tracked.
//  Ports       : clk           rising-edge clock
//                rst           synchronous active-high reset
//                bus (slave)   issue request, writeback report, stall,
//                              busy vector, outstanding count, err_spurious
//  Parameters  : REG_AW          register address width (r0 hardwired zero)
//                MAX_OUTSTANDING max long ops in flight (1..2**REG_AW-1)
//                WB_BYPASS       1: same-cycle writeback releases the stall
//                                0: release one cycle after writeback
//  Options     : HAZARD_SCOREBOARD_STATS_EN adds a saturating 16-bit count
//                of stalled cycles on bus.stall_cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW          = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WB_BYPASS       = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_scoreboard_if.slave bus
);
    localparam int                NREGS   = 2 ** REG_AW;
    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic              c_BYP   = (WB_BYPASS != 0);
    localparam logic [CNT_W-1:0]  c_MAXO  = CNT_W'(MAX_OUTSTANDING);

    logic [NREGS-1:0] r_busy;
    logic [CNT_W-1:0] r_outstanding;
    logic             r_errSpurious;

    logic [NREGS-1:0] w_hit;
    logic [NREGS-1:0] w_busyNext;
    logic             w_wbClear;
    logic             w_fullBlock;
    logic             w_stall;
    logic             w_fire;
    logic             w_set;

    // A register is a live hazard if pending and not being written back
    // right now through the bypass path. r0 can never hazard.
    assign w_hit[0] = 1'b0;
    for (genvar i = 1; i < NREGS; i++) begin : g_hit
        assign w_hit[i] = r_busy[i] &&
                          !(c_BYP && bus.wb_valid && (bus.wb_dest == REG_AW'(i)));
    end

    // Only a writeback to a genuinely pending register retires an entry;
    // anything else is flagged as spurious and leaves state untouched.
    assign w_wbClear = bus.wb_valid && (bus.wb_dest != '0) && r_busy[bus.wb_dest];

    // Admission of a new tracked writer when the table is full is allowed
    // only if a retirement in the same cycle frees a slot (bypass mode).
    assign w_fullBlock = bus.issue_regWrite && bus.issue_long &&
                         (bus.issue_dest != '0) &&
                         (r_outstanding == c_MAXO) &&
                         !(c_BYP && w_wbClear);

    // Built only from inputs and registered state, never from w_fire.
    assign w_stall = bus.issue_valid &&
                     ((bus.issue_use1     && w_hit[bus.issue_src1]) ||
                      (bus.issue_use2     && w_hit[bus.issue_src2]) ||
                      (bus.issue_regWrite && w_hit[bus.issue_dest]) ||
                      w_fullBlock);

    assign w_fire = bus.issue_valid && !w_stall;
    assign w_set  = w_fire && bus.issue_regWrite && bus.issue_long &&
                    (bus.issue_dest != '0);

    // Clear applied first so a set of the same register wins: the new
    // writer replaces the retiring one and stays tracked.
    always_comb begin
        w_busyNext = r_busy;
        if (w_wbClear) begin
            w_busyNext[bus.wb_dest] = 1'b0;
        end
        if (w_set) begin
            w_busyNext[bus.issue_dest] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            r_errSpurious <= 1'b0;
        end else begin
            r_busy        <= w_busyNext;
            // Cannot wrap: w_fullBlock prevents a net increment at the limit,
            // and w_wbClear implies at least one entry is pending.
            r_outstanding <= r_outstanding + CNT_W'(w_set) - CNT_W'(w_wbClear);
            r_errSpurious <= bus.wb_valid && !w_wbClear;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.busy         = r_busy;
    assign bus.outstanding  = r_outstanding;
    assign bus.err_spurious = r_errSpurious;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0] r_stallCycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
        end else if (w_stall && (r_stallCycles != 16'hFFFF)) begin
            r_stallCycles <= r_stallCycles + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stallCycles;
`endif

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. Directed
//                scenarios followed by randomized traffic, all compared
//                against a register-array reference model of the hazard
//                rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;
    localparam int REG_AW = 3;
    localparam int MAXO   = 4;
    localparam int BYPI   = 1;
    localparam int NREGS  = 2 ** REG_AW;
    localparam bit BYP    = (BYPI != 0);

    logic clk;
    logic rst;

    hazard_scoreboard_if #(.REG_AW(REG_AW), .MAX_OUTSTANDING(MAXO)) ifc ();

    hazard_scoreboard #(
        .REG_AW          (REG_AW),
        .MAX_OUTSTANDING (MAXO),
        .WB_BYPASS       (BYPI)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit mBusy [NREGS];
    int mOut;
    bit mErr;
    int mStallCnt;

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input bit v, input bit rw, input bit lg, input int d,
                       input int s1, input int s2, input bit u1, input bit u2,
                       input bit wv, input int wd);
        ifc.issue_valid    = v;
        ifc.issue_regWrite = rw;
        ifc.issue_long     = lg;
        ifc.issue_dest     = REG_AW'(d);
        ifc.issue_src1     = REG_AW'(s1);
        ifc.issue_src2     = REG_AW'(s2);
        ifc.issue_use1     = u1;
        ifc.issue_use2     = u2;
        ifc.wb_valid       = wv;
        ifc.wb_dest        = REG_AW'(wd);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic bit pendingNow(input int r);
        return mBusy[r] && (r != 0) &&
               !(BYP && ifc.wb_valid && (int'(ifc.wb_dest) == r));
    endfunction

    function automatic logic [NREGS-1:0] modelBusyVec();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = mBusy[i];
        return v;
    endfunction

    // One clock: check stall mid-cycle, advance model at the edge, then
    // check registered outputs. dirStall >= 0 adds a directed stall check.
    task automatic cycle(input bit doRst, input int dirStall);
        bit expStall, retire, fullBlk, fire, admit;
        int d, wd;
        rst = doRst;
        @(negedge clk);
        d      = int'(ifc.issue_dest);
        wd     = int'(ifc.wb_dest);
        retire = ifc.wb_valid && (wd != 0) && mBusy[wd];
        fullBlk = ifc.issue_regWrite && ifc.issue_long && (d != 0) &&
                  (mOut == MAXO) && !(BYP && retire);
        expStall = ifc.issue_valid &&
                   ((ifc.issue_use1 && pendingNow(int'(ifc.issue_src1))) ||
                    (ifc.issue_use2 && pendingNow(int'(ifc.issue_src2))) ||
                    (ifc.issue_regWrite && pendingNow(d)) || fullBlk);
        chk("stall", 32'(ifc.stall), 32'(expStall));
        if (dirStall >= 0) chk("dir_stall", 32'(ifc.stall), 32'(dirStall));
        fire  = ifc.issue_valid && !expStall;
        admit = fire && ifc.issue_regWrite && ifc.issue_long && (d != 0);
        @(posedge clk);
        #1;
        if (doRst) begin
            for (int i = 0; i < NREGS; i++) mBusy[i] = 1'b0;
            mOut = 0;
            mErr = 1'b0;
            mStallCnt = 0;
        end else begin
            if (retire) mBusy[wd] = 1'b0;
            if (admit)  mBusy[d]  = 1'b1;
            mOut = mOut + int'(admit) - int'(retire);
            mErr = ifc.wb_valid && !retire;
            if (expStall && mStallCnt < 16'hFFFF) mStallCnt++;
        end
        chk("busy", 32'(ifc.busy), 32'(modelBusyVec()));
        chk("outstanding", 32'(ifc.outstanding), 32'(mOut));
        chk("err_spurious", 32'(ifc.err_spurious), 32'(mErr));
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("stall_cycles", 32'(ifc.stall_cycles), 32'(mStallCnt));
`endif
    endtask

    task automatic randInputs();
        int q[$];
        int wd;
        for (int i = 1; i < NREGS; i++) if (mBusy[i]) q.push_back(i);
        if (q.size() != 0 && $urandom_range(3, 0) != 0)
            wd = q[$urandom_range(q.size() - 1, 0)];
        else
            wd = $urandom_range(NREGS - 1, 0);
        drv($urandom_range(9, 0) < 8, $urandom_range(9, 0) < 7, $urandom_range(1, 0) == 1,
            $urandom_range(NREGS - 1, 0), $urandom_range(NREGS - 1, 0),
            $urandom_range(NREGS - 1, 0), $urandom_range(1, 0) == 1,
            $urandom_range(1, 0) == 1, $urandom_range(9, 0) < 4, wd);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < NREGS; i++) mBusy[i] = 1'b0;
        mOut = 0; mErr = 1'b0; mStallCnt = 0;
        cycle(1, -1);
        cycle(1, -1);

        // Reset state and an issue with nothing pending
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_out", 32'(ifc.outstanding), 32'd0);
        drv(1, 1, 1, 5, 3, 4, 1, 1, 0, 0);
        cycle(0, 0);
        drv(1, 0, 0, 0, 1, 2, 1, 1, 1, 5);
        cycle(0, 0);

        // RAW on a long writer, released on the writeback cycle
        drv(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        cycle(0, 0);
        drv(1, 1, 0, 1, 3, 0, 1, 0, 0, 0);
        cycle(0, 1);
        cycle(0, 1);
        drv(1, 1, 0, 1, 3, 0, 1, 0, 1, 3);
        cycle(0, BYP ? 0 : 1);
        chk("s2_busy3", 32'(ifc.busy[3]), 32'd0);

        // r0 is never tracked
        drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0);
        drv(1, 1, 0, 2, 0, 0, 1, 1, 0, 0);
        cycle(0, 0);
        chk("s3_out", 32'(ifc.outstanding), 32'd0);
        chk("s3_busy", 32'(ifc.busy), 32'd0);

        // Fill the table, then admit r5 only alongside a retirement
        for (int r = 1; r <= 4; r++) begin
            drv(1, 1, 1, r, 0, 0, 0, 0, 0, 0);
            cycle(0, 0);
        end
        chk("s4_full", 32'(ifc.outstanding), 32'd4);
        drv(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        cycle(0, 1);
        drv(1, 1, 1, 5, 0, 0, 0, 0, 1, 1);
        cycle(0, BYP ? 0 : 1);
        chk("s4_out", 32'(ifc.outstanding), 32'd4);
        for (int r = 2; r <= 5; r++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 1, r);
            cycle(0, -1);
        end
        chk("s4_drain", 32'(ifc.outstanding), 32'd0);

        // Same-register set and clear: set wins
        drv(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
        cycle(0, 0);
        drv(1, 1, 1, 2, 0, 0, 0, 0, 1, 2);
        cycle(0, BYP ? 0 : 1);
        chk("s5_busy2", 32'(ifc.busy[2]), 32'd1);
        chk("s5_out", 32'(ifc.outstanding), 32'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        cycle(0, -1);

        // Spurious writeback pulse, then reset in the middle of activity
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        cycle(0, -1);
        chk("s6_err_on", 32'(ifc.err_spurious), 32'd1);
        idle();
        cycle(0, -1);
        chk("s6_err_off", 32'(ifc.err_spurious), 32'd0);
        drv(1, 1, 1, 6, 0, 0, 0, 0, 0, 0);
        cycle(0, -1);
        drv(1, 1, 1, 7, 0, 0, 0, 0, 1, 4);
        cycle(0, -1);
        drv(1, 1, 1, 3, 0, 0, 0, 0, 1, 6);
        cycle(1, -1);
        chk("s6_rst_busy", 32'(ifc.busy), 32'd0);
        chk("s6_rst_out", 32'(ifc.outstanding), 32'd0);
        chk("s6_rst_err", 32'(ifc.err_spurious), 32'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            randInputs();
            cycle($urandom_range(99, 0) == 0, -1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule : tb_hazard_scoreboard
`default_nettype wire
